stack_lane_port: RTL and testbench
==================================

Name: stack_lane_port

Overview:
- Per-lane requester for one read/write port pair of the 4R/4W Sephirot eBPF stack memory.
- Turns the lane's byte-addressed, sized load/store requests (1/2/4/8 bytes, little-endian) into 64-bit word accesses on the stack port.
- Sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses are rejected before any stack access.
- Sits between a Sephirot lane's execute stage and its stack read/write port.

Parameters:
- MAX_ENTRIES, 64: stack depth in 64-bit words. Must be a power of 2 and at least 2.
- RD_LAT, 1: stack read latency in cycles, from stack_read_add to valid stack_data_out. Range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  lane request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
- req_addr  in  64  byte address within the stack
- req_wdata  in  64  store data, right-aligned (low bytes used)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid: access rejected
- rsp_data  out  64  load data, zero-extended; 0 for stores and errors
- stack_read_add  out  64  to stack read_add_n
- stack_data_out  in  64  from stack data_out_n
- stack_wrt_add  out  64  to stack wrt_add_n
- stack_wrt_en  out  1  to stack wrt_en_n
- stack_data_in  out  64  to stack data_in_n

Behaviour:
- Reset (asynchronous, active-low) clears all outputs and state:
  - req_ready=1 once out of reset.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - stack_wrt_en=0, stack_read_add=0, stack_wrt_add=0, stack_data_in=0.
  - FSM goes to IDLE.
- Reset mid-operation aborts any in-flight access: no write is issued and no response is produced.
- A request is accepted on req_valid & req_ready. req_ready=1 only in IDLE. Requests are never queued. rsp_valid is never back-pressured.
- Address decode:
  - byte offset off = req_addr[2:0]
  - word index w = req_addr[63:3]
  - n = 1 << req_size bytes
- Error condition: req_addr is not a multiple of n, or w >= MAX_ENTRIES. On error there is no stack access; rsp_valid=1 and rsp_err=1 on the next cycle (T+1), rsp_data=0.
- All stack outputs are registered. stack_read_add and stack_wrt_add carry w zero-extended to 64 bits.
- FSM states: IDLE, RD_WAIT, LD_RSP, RMW_WR, WR, ERR_RSP.
  - IDLE, accept of an error -> ERR_RSP.
  - IDLE, accept of a load -> RD_WAIT. Drive stack_read_add=w from T+1 and load the latency counter with RD_LAT.
  - IDLE, accept of an 8B store -> WR.
  - IDLE, accept of a store with n<8 -> RD_WAIT, marked as an RMW.
  - RD_WAIT: decrement the counter each cycle. When it expires, capture stack_data_out. A load goes to LD_RSP; an RMW goes to RMW_WR.
  - LD_RSP: rsp_valid=1, rsp_data = captured word bytes [8*off +: 8*n], zero-extended. Return to IDLE.
  - RMW_WR: stack_wrt_en=1 for exactly one cycle. stack_data_in = captured word with bytes [8*off +: 8*n] replaced by req_wdata[8*n-1:0]. rsp_valid=1 in the following cycle, then IDLE.
  - WR: stack_wrt_en=1 for one cycle, stack_data_in=req_wdata. rsp_valid=1 in the following cycle, then IDLE.
  - ERR_RSP: one-cycle error response, then IDLE.
- Latency with accept at cycle T and RD_LAT=1:
  - load: rsp at T+3
  - 8B store: wrt_en at T+1, rsp at T+2
  - sub-word store: wrt_en at T+3, rsp at T+4
  - error: rsp at T+1
- In general, load rsp = T+2+RD_LAT and sub-word wrt_en = T+2+RD_LAT.
- stack_wrt_en is a single-cycle pulse and is never asserted outside WR or RMW_WR.
- RMW is not atomic with respect to other lanes. Cross-lane ordering is the compiler's responsibility.
- Back-to-back operation: the next request may be accepted in the cycle after rsp_valid. Its stack read must see the previous write, which relies on the stack's RDW=0 behaviour.
- Address and wdata are latched at accept; later changes to req_* inputs have no effect.

Test Plan:
- Reset is low while req_valid=1 -> req_ready=0 and no stack_wrt_en. After reset is released, req_ready=1 and all outputs are 0.
- 8B store of addr=0x10, wdata=0x1122334455667788 -> stack_wrt_add=2 and stack_wrt_en at T+1, rsp at T+2. Then an 8B load of 0x10 -> rsp_data=0x1122334455667788 at T+3.
- Sub-word store: with word 2 preset to 0x1122334455667788, a 2B store to addr=0x14 with wdata=0xBEEF -> stack read of word 2, then wrt_en at T+3 with data 0x1122BEEF55667788. A subsequent 1B load of 0x15 -> rsp_data=0xBE.
- Errors:
  - 4B load at addr=0x12 -> rsp_err=1 at T+1, no stack access.
  - 8B store at addr=0x200 (w=64) -> rsp_err=1, no stack_wrt_en.
- RD_LAT=3: 4B load of 0x8 -> rsp at T+5. req_ready stays 0 and a new req_valid is ignored until after rsp.
- Reset asserted during RMW_WR-1 (RD_WAIT) -> no stack_wrt_en and no rsp. The stack word stays unchanged.

Source files
------------

// File: rtl/stack_lane_port.sv
// Per-lane requester for one Sephirot stack read/write port pair.
// Sized little-endian lane loads/stores become 64-bit word accesses.
module stack_lane_port #(
    parameter int MAX_ENTRIES = 64,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [63:0] rsp_data,
    output logic [63:0] stack_read_add,
    input  logic [63:0] stack_data_out,
    output logic [63:0] stack_wrt_add,
    output logic        stack_wrt_en,
    output logic [63:0] stack_data_in
);

    localparam int AW = $clog2(MAX_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        LD_RSP,
        RMW_WR,
        WR,
        ERR_RSP
    } state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic        rmw, rmw_n;
    logic [2:0]  off, off_n;
    logic [1:0]  size, size_n;
    logic [63:0] wdata, wdata_n;

    logic        ready_n;
    logic        rsp_valid_n;
    logic        rsp_err_n;
    logic [63:0] rsp_data_n;
    logic [63:0] rd_add_n;
    logic [63:0] wr_add_n;
    logic        wr_en_n;
    logic [63:0] din_n;

    logic        accept;
    logic        misalign;
    logic        oob;
    logic [63:0] word_idx;
    logic [5:0]  sh;
    logic [63:0] smask;
    logic [63:0] bmask;
    logic [63:0] ld_data;
    logic [63:0] merged;

    assign accept   = req_valid && req_ready;
    assign oob      = |req_addr[63:3+AW];
    assign word_idx = 64'(req_addr[3 +: AW]);

    always_comb begin
        misalign = 1'b0;
        unique case (req_size)
            2'd0: misalign = 1'b0;
            2'd1: misalign = req_addr[0];
            2'd2: misalign = |req_addr[1:0];
            2'd3: misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Lane bytes of the latched access, as a mask over the 64-bit word.
    always_comb begin
        smask = '1;
        unique case (size)
            2'd0: smask = 64'h0000_0000_0000_00ff;
            2'd1: smask = 64'h0000_0000_0000_ffff;
            2'd2: smask = 64'h0000_0000_ffff_ffff;
            2'd3: smask = '1;
            default: smask = '1;
        endcase
    end

    assign sh      = {off, 3'b000};
    assign bmask   = smask << sh;
    assign ld_data = (stack_data_out >> sh) & smask;
    assign merged  = (stack_data_out & ~bmask)
                   | ((wdata << sh) & bmask);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rmw_n       = rmw;
        off_n       = off;
        size_n      = size;
        wdata_n     = wdata;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_data_n  = '0;
        rd_add_n    = stack_read_add;
        wr_add_n    = stack_wrt_add;
        wr_en_n     = 1'b0;
        din_n       = stack_data_in;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    off_n   = req_addr[2:0];
                    size_n  = req_size;
                    wdata_n = req_wdata;
                    if (misalign || oob) begin
                        state_n     = ERR_RSP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (req_we && req_size == 2'd3) begin
                        state_n  = WR;
                        wr_en_n  = 1'b1;
                        wr_add_n = word_idx;
                        din_n    = req_wdata;
                    end else begin
                        state_n  = RD_WAIT;
                        rd_add_n = word_idx;
                        cnt_n    = 2'(RD_LAT);
                        rmw_n    = req_we;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 2'd0) begin
                    if (rmw) begin
                        state_n  = RMW_WR;
                        wr_en_n  = 1'b1;
                        wr_add_n = stack_read_add;
                        din_n    = merged;
                    end else begin
                        state_n     = LD_RSP;
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = ld_data;
                    end
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            LD_RSP, ERR_RSP: begin
                state_n = IDLE;
            end
            RMW_WR, WR: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A write's response cycle is spent in IDLE, so hold off accepts.
        ready_n = (state_n == IDLE) && !rsp_valid_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rmw            <= 1'b0;
            off            <= '0;
            size           <= '0;
            wdata          <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            stack_read_add <= '0;
            stack_wrt_add  <= '0;
            stack_wrt_en   <= 1'b0;
            stack_data_in  <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            rmw            <= rmw_n;
            off            <= off_n;
            size           <= size_n;
            wdata          <= wdata_n;
            req_ready      <= ready_n;
            rsp_valid      <= rsp_valid_n;
            rsp_err        <= rsp_err_n;
            rsp_data       <= rsp_data_n;
            stack_read_add <= rd_add_n;
            stack_wrt_add  <= wr_add_n;
            stack_wrt_en   <= wr_en_n;
            stack_data_in  <= din_n;
        end
    end

endmodule

// File: tb/tb_stack_lane_port.sv
// Directed bench for stack_lane_port: one lane at RD_LAT=1, one at
// RD_LAT=3, each backed by a small behavioural stack.
module tb_stack_lane_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v1, v3;
    logic        req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;

    logic        rdy1, rv1, re1, we1;
    logic [63:0] rd1, ra1, sdo1, wa1, di1;
    logic        rdy3, rv3, re3, we3;
    logic [63:0] rd3, ra3, sdo3, wa3, di3;

    logic [63:0] mem1 [64];
    logic [63:0] mem3 [64];
    logic [63:0] p1, p3a, p3b, p3c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_lane_port #(.MAX_ENTRIES(64), .RD_LAT(1)) u1 (
        .clk(clk), .reset(rst_n),
        .req_valid(v1), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_err(re1), .rsp_data(rd1),
        .stack_read_add(ra1), .stack_data_out(sdo1),
        .stack_wrt_add(wa1), .stack_wrt_en(we1),
        .stack_data_in(di1)
    );

    stack_lane_port #(.MAX_ENTRIES(64), .RD_LAT(3)) u3 (
        .clk(clk), .reset(rst_n),
        .req_valid(v3), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_err(re3), .rsp_data(rd3),
        .stack_read_add(ra3), .stack_data_out(sdo3),
        .stack_wrt_add(wa3), .stack_wrt_en(we3),
        .stack_data_in(di3)
    );

    always @(posedge clk) begin
        if (we1) mem1[wa1[5:0]] <= di1;
        p1 <= mem1[ra1[5:0]];
    end
    assign sdo1 = p1;

    always @(posedge clk) begin
        if (we3) mem3[wa3[5:0]] <= di3;
        p3a <= mem3[ra3[5:0]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign sdo3 = p3c;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction; records cycle offsets from the accept edge.
    task automatic xact(input int sel,
                        input logic we, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] d,
                        output int t_we, output int t_rsp,
                        output int n_we, output int n_rsp,
                        output logic [63:0] rdat, output logic err,
                        output logic [63:0] wadd, output logic [63:0] wdin);
        @(negedge clk);
        req_we = we; req_size = sz; req_addr = a; req_wdata = d;
        if (sel == 1) v1 = 1'b1; else v3 = 1'b1;
        chk("accept_ready", (sel == 1) ? rdy1 : rdy3, 1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v3 = 1'b0;
        req_addr = 64'h0; req_wdata = ~d;
        t_we = -1; t_rsp = -1; n_we = 0; n_rsp = 0;
        rdat = '0; err = 1'b0; wadd = '0; wdin = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if ((sel == 1) ? we1 : we3) begin
                n_we++;
                if (t_we < 0) t_we = k;
                wadd = (sel == 1) ? wa1 : wa3;
                wdin = (sel == 1) ? di1 : di3;
            end
            if ((sel == 1) ? rv1 : rv3) begin
                n_rsp++;
                if (t_rsp < 0) begin
                    t_rsp = k;
                    rdat = (sel == 1) ? rd1 : rd3;
                    err = (sel == 1) ? re1 : re3;
                end
            end
        end
    endtask

    initial begin
        int tw, tr, nw, nr, nrdy, cw;
        logic [63:0] rd, wa, wd;
        logic er;

        rst_n = 1'b0; v1 = 1'b1; v3 = 1'b0;
        req_we = 1'b1; req_size = 2'd3;
        req_addr = 64'h10; req_wdata = '1;
        cw = 0;
        repeat (4) begin
            @(negedge clk);
            if (we1 || we3) cw++;
        end
        chk("rst_ready", rdy1, 0);
        chk("rst_wen", cw, 0);
        v1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("por_ready", rdy1, 1);
        chk("por_outs", {rv1, re1, we1}, 0);
        chk("por_rdata", rd1, 0);
        chk("por_radd", ra1, 0);
        chk("por_wadd", wa1, 0);
        chk("por_din", di1, 0);

        xact(1, 1, 3, 64'h10, 64'h1122334455667788,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("st8_twe", tw, 1);
        chk("st8_wadd", wa, 2);
        chk("st8_din", wd, 64'h1122334455667788);
        chk("st8_trsp", tr, 2);
        chk("st8_nwe", nw, 1);
        chk("st8_rdata", rd, 0);

        xact(1, 0, 3, 64'h10, 64'h0,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("ld8_trsp", tr, 3);
        chk("ld8_data", rd, 64'h1122334455667788);
        chk("ld8_nwe", nw, 0);

        xact(1, 1, 1, 64'h14, 64'hffff_ffff_ffff_beef,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("rmw_twe", tw, 3);
        chk("rmw_wadd", wa, 2);
        chk("rmw_din", wd, 64'h1122beef55667788);
        chk("rmw_trsp", tr, 4);
        chk("rmw_nwe", nw, 1);

        xact(1, 0, 0, 64'h15, 64'h0,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("ld1_trsp", tr, 3);
        chk("ld1_data", rd, 64'hbe);

        xact(1, 0, 2, 64'h12, 64'h0,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("mis_trsp", tr, 1);
        chk("mis_err", er, 1);
        chk("mis_data", rd, 0);
        chk("mis_nwe", nw, 0);

        xact(1, 1, 3, 64'h200, 64'hdead,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("oob_trsp", tr, 1);
        chk("oob_err", er, 1);
        chk("oob_nwe", nw, 0);
        chk("oob_nrsp", nr, 1);

        xact(1, 1, 1, 64'h11, 64'h1234,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("mis2_err", er, 1);
        chk("mis2_nwe", nw, 0);

        xact(3, 1, 3, 64'h8, 64'ha1b2c3d4e5f60718,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("l3st_twe", tw, 1);
        chk("l3st_wadd", wa, 1);

        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2;
        req_addr = 64'h8; v3 = 1'b1;
        chk("l3_ready", rdy3, 1);
        @(posedge clk);
        #1;
        req_addr = 64'h18;
        tr = -1; nr = 0; nrdy = 0; rd = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tr < 0 && rdy3) nrdy++;
            if (rv3) begin
                nr++;
                if (tr < 0) begin
                    tr = k;
                    rd = rd3;
                end
                v3 = 1'b0;
            end
        end
        v3 = 1'b0;
        chk("l3_trsp", tr, 5);
        chk("l3_data", rd, 64'he5f60718);
        chk("l3_busy_ready", nrdy, 0);
        chk("l3_nrsp", nr, 1);
        chk("l3_radd", ra3, 1);

        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1;
        req_addr = 64'h10; req_wdata = 64'hdead;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        nw = 0; nr = 0;
        repeat (4) begin
            @(negedge clk);
            if (we1) nw++;
            if (rv1) nr++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (we1) nw++;
            if (rv1) nr++;
        end
        chk("abort_nwe", nw, 0);
        chk("abort_nrsp", nr, 0);

        xact(1, 0, 3, 64'h10, 64'h0,
             tw, tr, nw, nr, rd, er, wa, wd);
        chk("abort_word", rd, 64'h1122beef55667788);
        chk("abort_ld_trsp", tr, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
